run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL provide parameter CLEAR_MEM, default 1; when 1, a post-reset clear phase runs; when 0, it is skipped.
REQ-002 SHALL provide parameter DM_DEPTH, default 256; this is the number of data-memory words cleared (range 16..256).
REQ-003 SHALL provide the following ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  program request from the bench or host; a launch is triggered when it goes high and then low.
- Halt  input  1  decoder flag: the current instruction is the terminating instruction.
- Ack  output  1  program-done flag to the host.
- PcInit  output  1  forces the program counter to 0.
- Run  output  1  enables PC advance and register/memory writes by the datapath.
- ClrEn  output  1  data-memory clear-write enable.
- RfClrEn  output  1  register-file clear-write enable.
- ClrAddr  output  8  clear address, driving the DM address and RF address [3:0]; clear data is 0.
- CycleCnt  output  16  number of RUN cycles in the current or last program.

Function
REQ-004 SHALL implement states CLEAR, IDLE, ARMED, RUN, DONE; all outputs registered or decoded from state/counters only (no combinational path from inputs to outputs).
REQ-005 Output decode per state:
- CLEAR: ClrEn=1, PcInit=1, Run=0, Ack=0.
- IDLE and ARMED: PcInit=1, Run=0, Ack=0, ClrEn=0.
- RUN: Run=1, PcInit=0, Ack=0.
- DONE: Ack=1, Run=0, PcInit=0 (PC frozen for inspection).
REQ-006 CLEAR SHALL step ClrAddr 0,1,...,DM_DEPTH-1, one per cycle; RfClrEn=1 only while in CLEAR and ClrAddr<16.
REQ-007 CLEAR->IDLE SHALL occur on the edge after ClrAddr=DM_DEPTH-1; ClrAddr SHALL return to 0 on that edge.
REQ-008 IDLE->ARMED SHALL occur when Start=1 is sampled.
REQ-009 ARMED SHALL remain while Start=1; ARMED->RUN SHALL occur when Start=0 is sampled, so Run=1 in the cycle following the first low sample.
REQ-010 CycleCnt SHALL clear to 0 on every entry to ARMED.
REQ-011 CycleCnt SHALL increment by 1 on each edge where state=RUN, including the Halt cycle, and saturate at 16'hFFFF (no wrap).
REQ-012 RUN->DONE SHALL occur when Halt=1 is sampled in RUN; Ack=1 from the next cycle.
REQ-013 Start=1 sampled in RUN SHALL abort the program: RUN->ARMED, taking priority over a simultaneous Halt.
REQ-014 DONE SHALL hold Ack=1 and CycleCnt until Start=1 is sampled; DONE->ARMED then, with Ack=0 the following cycle.
REQ-015 Halt SHALL be ignored in CLEAR, IDLE, ARMED and DONE.
REQ-016 Start SHALL be ignored in CLEAR; the clear phase is non-interruptible except by Reset.

Reset
REQ-017 Reset=1 at any edge, in any state, SHALL set the state to CLEAR if CLEAR_MEM=1, otherwise to IDLE.
REQ-018 The same reset SHALL set ClrAddr=0, CycleCnt=0, Ack=0, Run=0, PcInit=1.
REQ-019 While Reset is held, outputs SHALL match the CLEAR (or IDLE) decode with ClrAddr=0.
REQ-020 Reset asserted mid-CLEAR, mid-RUN or in DONE SHALL restart the sequence per REQ-017; no partial state is retained.

Verification
REQ-021 Post-reset clear: Reset 2 cycles then low -> ClrEn=1 for exactly 256 cycles, ClrAddr 0..255, RfClrEn=1 for the first 16, then IDLE with PcInit=1, Run=0.
REQ-022 Launch and halt: Start high 3 cycles then low, Halt pulsed on the 10th RUN cycle -> Run high 10 cycles, Ack=1 the next cycle, CycleCnt=10, PcInit=0 in DONE.
REQ-023 Ack release: in DONE, drive Start=1 -> Ack=0 the next cycle, CycleCnt=0; Start low -> new RUN begins.
REQ-024 Abort: Start=1 together with Halt=1 on RUN cycle 5 -> ARMED (not DONE), Ack stays 0, CycleCnt=0.
REQ-025 Spurious Halt and reset mid-clear: Halt=1 in IDLE -> no state change, Ack=0; Reset at ClrAddr=100 -> ClrAddr=0 next cycle and the full 256-cycle clear repeats.
REQ-026 Saturation with CLEAR_MEM=0: reset goes straight to IDLE; RUN 70000 cycles without Halt -> CycleCnt=16'hFFFF, Run still 1.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller: optional post-reset memory/register clear, start handshake,
// program run with saturating cycle counter, and done/acknowledge hold.
module run_ctrl #(
  parameter int unsigned CLEAR_MEM = 1,
  parameter int unsigned DM_DEPTH  = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Halt,
  output logic        Ack,
  output logic        PcInit,
  output logic        Run,
  output logic        ClrEn,
  output logic        RfClrEn,
  output logic [7:0]  ClrAddr,
  output logic [15:0] CycleCnt
);

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] ST_RESET  = (CLEAR_MEM != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [7:0] LAST_ADDR = 8'(DM_DEPTH - 1);

  logic [2:0]  state_r;
  logic [2:0]  state_next_s;
  logic [7:0]  clr_addr_r;
  logic [7:0]  addr_next_s;
  logic [15:0] cycle_cnt_r;
  logic [15:0] cnt_next_s;
  logic        ack_r;
  logic        run_r;
  logic        pc_init_r;
  logic        clr_en_r;
  logic        rf_clr_en_r;

  // The run counter must stick at all-ones rather than wrap on very long programs.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      sat_inc = 16'hFFFF;
    end else begin
      sat_inc = value + 16'd1;
    end
  endfunction

  // Next-state, clear-address and cycle-count computation.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = clr_addr_r;
    cnt_next_s   = cycle_cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_addr_r == LAST_ADDR) begin
          state_next_s = ST_IDLE;
          addr_next_s  = 8'd0;
        end else begin
          addr_next_s  = clr_addr_r + 8'd1;
        end
      end
      ST_IDLE: begin
        if (Start) state_next_s = ST_ARMED;
        else       state_next_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (Start) state_next_s = ST_ARMED;
        else       state_next_s = ST_RUN;
      end
      ST_RUN: begin
        // An abort request outranks a halt arriving in the same cycle.
        if (Start)     state_next_s = ST_ARMED;
        else if (Halt) state_next_s = ST_DONE;
        else           state_next_s = ST_RUN;
      end
      ST_DONE: begin
        if (Start) state_next_s = ST_ARMED;
        else       state_next_s = ST_DONE;
      end
      default: begin
        state_next_s = ST_RESET;
        addr_next_s  = 8'd0;
      end
    endcase

    if (state_next_s == ST_ARMED) begin
      cnt_next_s = 16'd0;
    end else if (state_r == ST_RUN) begin
      cnt_next_s = sat_inc(cycle_cnt_r);
    end else begin
      cnt_next_s = cycle_cnt_r;
    end
  end

  // State, counters and outputs; outputs are registered from the next-state decode.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_RESET;
      clr_addr_r  <= 8'd0;
      cycle_cnt_r <= 16'd0;
      ack_r       <= 1'b0;
      run_r       <= 1'b0;
      pc_init_r   <= 1'b1;
      clr_en_r    <= (ST_RESET == ST_CLEAR);
      rf_clr_en_r <= (ST_RESET == ST_CLEAR);
    end else begin
      state_r     <= state_next_s;
      clr_addr_r  <= addr_next_s;
      cycle_cnt_r <= cnt_next_s;
      ack_r       <= (state_next_s == ST_DONE);
      run_r       <= (state_next_s == ST_RUN);
      pc_init_r   <= (state_next_s == ST_CLEAR) || (state_next_s == ST_IDLE) ||
                     (state_next_s == ST_ARMED);
      clr_en_r    <= (state_next_s == ST_CLEAR);
      rf_clr_en_r <= (state_next_s == ST_CLEAR) && (addr_next_s < 8'd16);
    end
  end

  assign Ack      = ack_r;
  assign Run      = run_r;
  assign PcInit   = pc_init_r;
  assign ClrEn    = clr_en_r;
  assign RfClrEn  = rf_clr_en_r;
  assign ClrAddr  = clr_addr_r;
  assign CycleCnt = cycle_cnt_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl: one instance with the clear phase
// enabled and one without, the latter used for the counter saturation run.
module tb_run_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start, Halt;
  logic        Ack, PcInit, Run, ClrEn, RfClrEn;
  logic [7:0]  ClrAddr;
  logic [15:0] CycleCnt;

  logic        Reset2, Start2, Halt2;
  logic        Ack2, PcInit2, Run2, ClrEn2, RfClrEn2;
  logic [7:0]  ClrAddr2;
  logic [15:0] CycleCnt2;

  int n_chk  = 0;
  int n_pass = 0;
  int clr_cycles;

  always #5 Clk = ~Clk;

  run_ctrl #(.CLEAR_MEM(1), .DM_DEPTH(256)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .Ack(Ack), .PcInit(PcInit), .Run(Run), .ClrEn(ClrEn), .RfClrEn(RfClrEn),
    .ClrAddr(ClrAddr), .CycleCnt(CycleCnt)
  );

  run_ctrl #(.CLEAR_MEM(0), .DM_DEPTH(256)) dut_nc (
    .Clk(Clk), .Reset(Reset2), .Start(Start2), .Halt(Halt2),
    .Ack(Ack2), .PcInit(PcInit2), .Run(Run2), .ClrEn(ClrEn2), .RfClrEn(RfClrEn2),
    .ClrAddr(ClrAddr2), .CycleCnt(CycleCnt2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Ack, Run, PcInit, ClrEn packed as a nibble for compact decode checks.
  function automatic logic [31:0] ctl();
    return {28'd0, Ack, Run, PcInit, ClrEn};
  endfunction

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0;
    Reset2 = 1'b1; Start2 = 1'b0; Halt2 = 1'b0;

    // Reset held two cycles: CLEAR decode with address 0.
    tick(2);
    chk("rst_ctl", ctl(), 32'b0011);
    chk("rst_addr", 32'(ClrAddr), 32'd0);
    chk("rst_cnt", 32'(CycleCnt), 32'd0);
    chk("rst_rfclr", 32'(RfClrEn), 32'd1);
    Reset = 1'b0;

    // Full clear sweep; a Start pulse in the middle must be ignored.
    for (int i = 0; i < 256; i++) begin
      chk("clr_addr", 32'(ClrAddr), 32'(i));
      chk("clr_ctl", ctl(), 32'b0011);
      chk("clr_rf", 32'(RfClrEn), 32'(i < 16));
      Start = (i == 50);
      tick(1);
    end
    Start = 1'b0;
    chk("idle_ctl", ctl(), 32'b0010);
    chk("idle_addr", 32'(ClrAddr), 32'd0);
    chk("idle_rf", 32'(RfClrEn), 32'd0);

    // Spurious Halt in IDLE.
    Halt = 1'b1;
    tick(1);
    Halt = 1'b0;
    chk("idle_halt_ctl", ctl(), 32'b0010);
    tick(1);
    chk("idle_halt_ctl2", ctl(), 32'b0010);

    // Launch: Start high three cycles, then low.
    Start = 1'b1;
    tick(1);
    chk("armed_ctl", ctl(), 32'b0010);
    chk("armed_cnt", 32'(CycleCnt), 32'd0);
    tick(2);
    chk("armed_hold_ctl", ctl(), 32'b0010);
    Start = 1'b0;
    tick(1);
    for (int k = 1; k <= 10; k++) begin
      chk("run_ctl", ctl(), 32'b0100);
      chk("run_cnt", 32'(CycleCnt), 32'(k - 1));
      Halt = (k == 10);
      tick(1);
    end
    Halt = 1'b0;
    chk("done_ctl", ctl(), 32'b1000);
    chk("done_cnt", 32'(CycleCnt), 32'd10);

    // Halt ignored in DONE; Ack and count held.
    Halt = 1'b1;
    tick(2);
    Halt = 1'b0;
    chk("done_hold_ctl", ctl(), 32'b1000);
    chk("done_hold_cnt", 32'(CycleCnt), 32'd10);

    // Ack release and relaunch.
    Start = 1'b1;
    tick(1);
    chk("rel_ctl", ctl(), 32'b0010);
    chk("rel_cnt", 32'(CycleCnt), 32'd0);
    Start = 1'b0;
    tick(1);
    chk("rerun_ctl", ctl(), 32'b0100);
    chk("rerun_cnt", 32'(CycleCnt), 32'd0);

    // Abort on RUN cycle 5 with simultaneous Halt.
    tick(4);
    chk("pre_abort_cnt", 32'(CycleCnt), 32'd4);
    Start = 1'b1; Halt = 1'b1;
    tick(1);
    Halt = 1'b0;
    chk("abort_ctl", ctl(), 32'b0010);
    chk("abort_cnt", 32'(CycleCnt), 32'd0);
    Start = 1'b0;
    tick(1);
    chk("post_abort_ctl", ctl(), 32'b0100);
    tick(3);
    chk("post_abort_cnt", 32'(CycleCnt), 32'd3);

    // Reset mid-RUN restarts the clear phase.
    Reset = 1'b1;
    tick(1);
    chk("rst_run_ctl", ctl(), 32'b0011);
    chk("rst_run_cnt", 32'(CycleCnt), 32'd0);
    chk("rst_run_addr", 32'(ClrAddr), 32'd0);
    Reset = 1'b0;
    tick(100);
    chk("midclr_addr", 32'(ClrAddr), 32'd100);

    // Reset mid-clear: address back to 0 and a full 256-cycle clear repeats.
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("midclr_rst_addr", 32'(ClrAddr), 32'd0);
    clr_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (ClrEn) clr_cycles++;
      tick(1);
    end
    chk("reclr_len", 32'(clr_cycles), 32'd256);
    chk("reclr_idle_ctl", ctl(), 32'b0010);

    // Reach DONE quickly, then reset from DONE.
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(1);
    Halt = 1'b1;
    tick(1);
    Halt = 1'b0;
    chk("done2_ctl", ctl(), 32'b1000);
    chk("done2_cnt", 32'(CycleCnt), 32'd1);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("rst_done_ctl", ctl(), 32'b0011);
    chk("rst_done_cnt", 32'(CycleCnt), 32'd0);

    // No-clear instance: reset lands in IDLE, then saturation run.
    tick(1);
    chk("nc_rst_ctl", {28'd0, Ack2, Run2, PcInit2, ClrEn2}, 32'b0010);
    chk("nc_rst_rf", 32'(RfClrEn2), 32'd0);
    Reset2 = 1'b0;
    tick(1);
    chk("nc_idle_ctl", {28'd0, Ack2, Run2, PcInit2, ClrEn2}, 32'b0010);
    chk("nc_idle_addr", 32'(ClrAddr2), 32'd0);
    Start2 = 1'b1;
    tick(1);
    Start2 = 1'b0;
    tick(1);
    chk("nc_run_ctl", {28'd0, Ack2, Run2, PcInit2, ClrEn2}, 32'b0100);
    tick(65534);
    chk("nc_cnt_fffe", 32'(CycleCnt2), 32'h0000FFFE);
    tick(1);
    chk("nc_cnt_ffff", 32'(CycleCnt2), 32'h0000FFFF);
    tick(70000 - 65535);
    chk("nc_sat_cnt", 32'(CycleCnt2), 32'h0000FFFF);
    chk("nc_sat_run", 32'(Run2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
